decoder_pipe: RTL and testbench

//  Two-stage pipelined SECDED decoder; consumes codewords produced by the encoder stage.

---
 rtl/ecc_pkg.sv | 67 ++++++
 rtl/ecc_syndrome.sv | 44 ++++
 rtl/decoder_pipe.sv | 130 +++++++++++++
 tb/tb_decoder_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the encoder and decoder stages.
// Codeword layout: {data, parity}, right-justified, parity in the LSBs.
// Column scheme: every parity column is one-hot; every data column is a
// distinct odd-weight (>=3) value. Any double error therefore gives an
// even-weight non-zero syndrome, which cannot match a column.
package ecc_pkg;

    localparam int unsigned CW_BUS_W = 32;
    localparam int unsigned SYN_W    = 6;
    localparam int unsigned MAX_DATA = 26;
    localparam int unsigned POS_W    = 5;

    typedef enum logic [1:0] {
        CW8        = 2'b00,
        CW16       = 2'b01,
        CW32       = 2'b10,
        CW_ILLEGAL = 2'b11
    } cw_width_e;

    localparam int unsigned DATA_BITS [4] = '{4, 11, 26, 0};
    localparam int unsigned PAR_BITS  [4] = '{4, 5, 6, 0};

    // Data-bit H-columns: all odd-weight (>=3) 6-bit values in ascending
    // order. The 8b and 16b modes use the leading 4 / 11 entries, which
    // already fit in 4 / 5 bits.
    localparam logic [SYN_W-1:0] H_COL [MAX_DATA] = '{
        6'd7,  6'd11, 6'd13, 6'd14, 6'd19, 6'd21, 6'd22, 6'd25, 6'd26,
        6'd28, 6'd31, 6'd35, 6'd37, 6'd38, 6'd41, 6'd42, 6'd44, 6'd47,
        6'd49, 6'd50, 6'd52, 6'd55, 6'd56, 6'd59, 6'd61, 6'd62
    };

    // Parity over a right-justified data field.
    function automatic logic [SYN_W-1:0] calc_parity(input cw_width_e w,
                                                     input logic [MAX_DATA-1:0] data);
        logic [SYN_W-1:0] p;
        p = '0;
        for (int i = 0; i < int'(MAX_DATA); i++) begin
            if (i < int'(DATA_BITS[w]) && data[i]) begin
                p = p ^ H_COL[i];
            end
        end
        return p;
    endfunction

    // Data field of a codeword, zero-extended.
    function automatic logic [MAX_DATA-1:0] get_data(input cw_width_e w,
                                                     input logic [CW_BUS_W-1:0] cw);
        case (w)
            CW8:     return MAX_DATA'(cw[7:4]);
            CW16:    return MAX_DATA'(cw[15:5]);
            CW32:    return cw[31:6];
            default: return '0;
        endcase
    endfunction

    // Parity field of a codeword, zero-extended.
    function automatic logic [SYN_W-1:0] get_par(input cw_width_e w,
                                                 input logic [CW_BUS_W-1:0] cw);
        case (w)
            CW8:     return SYN_W'(cw[3:0]);
            CW16:    return SYN_W'(cw[4:0]);
            CW32:    return cw[5:0];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Syndrome classifier: maps (width, syndrome) to an error position in
// codeword coordinates, a corrected flag, or a fatal flag.
//   i_width   : codeword mode of the beat
//   i_syn     : received parity XOR recomputed parity
//   o_err_pos : codeword bit to flip when o_corr is set
//   o_corr    : syndrome matched exactly one H-column
//   o_fatal   : illegal width or syndrome matching no column
module ecc_syndrome
    import ecc_pkg::*;
(
    input  cw_width_e        i_width,
    input  logic [SYN_W-1:0] i_syn,
    output logic [POS_W-1:0] o_err_pos,
    output logic             o_corr,
    output logic             o_fatal
);

    // Column match; fatal by default once the syndrome is non-zero.
    always_comb begin
        o_err_pos = '0;
        o_corr    = 1'b0;
        o_fatal   = 1'b0;
        if (i_width == CW_ILLEGAL) begin
            o_fatal = 1'b1;
        end else if (i_syn != '0) begin
            o_fatal = 1'b1;
            for (int j = 0; j < int'(SYN_W); j++) begin
                if (j < int'(PAR_BITS[i_width]) && i_syn == SYN_W'(32'd1 << j)) begin
                    o_corr    = 1'b1;
                    o_fatal   = 1'b0;
                    o_err_pos = POS_W'(j);
                end
            end
            for (int i = 0; i < int'(MAX_DATA); i++) begin
                if (i < int'(DATA_BITS[i_width]) && i_syn == H_COL[i]) begin
                    o_corr    = 1'b1;
                    o_fatal   = 1'b0;
                    o_err_pos = POS_W'(int'(PAR_BITS[i_width]) + i);
                end
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Two-stage pipelined SECDED decoder with saturating error counters.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : codeword handshake (in_ready combinational)
//   codeword_width      : 00=8b, 01=16b, 10=32b, 11=illegal
//   data_in             : codeword, parity in LSBs
//   out_valid/out_ready : decoded-beat handshake
//   data_out            : corrected data, zero-extended (0 when fatal)
//   err_corr/err_fatal  : per-beat error flags
//   cnt_clr             : sync clear of both counters
//   corr_cnt/fatal_cnt  : saturating counts of delivered flagged beats
module decoder_pipe
    import ecc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            codeword_width,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err_corr,
    output logic                  err_fatal,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  corr_cnt,
    output logic [CNT_WIDTH-1:0]  fatal_cnt
);

    logic                  r_v1;
    cw_width_e             r_w1;
    logic [MAX_DATA-1:0]   r_d1;
    logic [SYN_W-1:0]      r_syn1;

    cw_width_e             w_w_in;
    logic [MAX_DATA-1:0]   w_d_in;
    logic [SYN_W-1:0]      w_syn_in;
    logic                  w_adv2;
    logic                  w_deliver;
    logic [POS_W-1:0]      w_err_pos;
    logic                  w_corr;
    logic                  w_fatal;
    logic [POS_W-1:0]      w_par_bits;
    logic [CW_BUS_W-1:0]   w_data_corr;

    assign w_w_in    = cw_width_e'(codeword_width);
    assign w_d_in    = get_data(w_w_in, CW_BUS_W'(data_in));
    assign w_syn_in  = get_par(w_w_in, CW_BUS_W'(data_in)) ^ calc_parity(w_w_in, w_d_in);

    // in_ready is held low during reset so it first rises after release.
    assign w_adv2    = !out_valid || out_ready;
    assign in_ready  = !rst && (!r_v1 || w_adv2);
    assign w_deliver = out_valid && out_ready;

    // S1: capture width, data field and syndrome; bubble when nothing offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_w1   <= CW8;
            r_d1   <= '0;
            r_syn1 <= '0;
        end else if (in_ready) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_w1   <= w_w_in;
                r_d1   <= w_d_in;
                r_syn1 <= w_syn_in;
            end
        end
    end

    ecc_syndrome u_syn (
        .i_width   (r_w1),
        .i_syn     (r_syn1),
        .o_err_pos (w_err_pos),
        .o_corr    (w_corr),
        .o_fatal   (w_fatal)
    );

    assign w_par_bits = POS_W'(PAR_BITS[r_w1]);

    // Flip only data-field positions; parity-bit hits leave data untouched.
    always_comb begin
        w_data_corr = CW_BUS_W'(r_d1);
        if (w_fatal) begin
            w_data_corr = '0;
        end else if (w_corr && w_err_pos >= w_par_bits) begin
            w_data_corr = w_data_corr ^ (CW_BUS_W'(1) << (w_err_pos - w_par_bits));
        end
    end

    // S2: output register, held while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            err_corr  <= 1'b0;
            err_fatal <= 1'b0;
        end else if (w_adv2) begin
            out_valid <= r_v1;
            if (r_v1) begin
                data_out  <= DATA_WIDTH'(w_data_corr);
                err_corr  <= w_corr;
                err_fatal <= w_fatal;
            end
        end
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt  <= '0;
            fatal_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt  <= '0;
            fatal_cnt <= '0;
        end else if (w_deliver) begin
            if (err_corr && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_WIDTH'(1);
            end
            if (err_fatal && fatal_cnt != '1) begin
                fatal_cnt <= fatal_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

    localparam int unsigned DW   = 32;
    localparam int unsigned CNTW = 2;
    localparam int          CMAX = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      codeword_width;
    logic [DW-1:0]   data_in;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   data_out;
    logic            err_corr;
    logic            err_fatal;
    logic            cnt_clr;
    logic [CNTW-1:0] corr_cnt;
    logic [CNTW-1:0] fatal_cnt;

    decoder_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .codeword_width (codeword_width),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .err_corr       (err_corr),
        .err_fatal      (err_fatal),
        .cnt_clr        (cnt_clr),
        .corr_cnt       (corr_cnt),
        .fatal_cnt      (fatal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        corr;
        logic        fatal;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_corr = 0;
    int   model_fatal = 0;
    int   accepts = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input logic c, input logic f);
        exp_t e;
        e.data  = d;
        e.corr  = c;
        e.fatal = f;
        return e;
    endfunction

    // Reference encoder: data column n is the n-th odd-weight (>=3) value
    // found by scanning upward through the P-bit space.
    function automatic logic [31:0] enc(input logic [1:0] w, input logic [31:0] d);
        int p;
        int k;
        int n;
        logic [31:0] par;
        logic [31:0] msk;
        p   = (w == 2'b00) ? 4 : (w == 2'b01) ? 5 : 6;
        k   = (w == 2'b00) ? 4 : (w == 2'b01) ? 11 : 26;
        par = '0;
        n   = 0;
        for (int v = 1; v < (1 << p); v++) begin
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1) begin
                if (n < k && d[n]) par = par ^ 32'(v);
                n++;
            end
        end
        msk = (32'd1 << k) - 32'd1;
        return ((d & msk) << p) | par;
    endfunction

    task automatic send(input logic [1:0] w, input logic [31:0] cw, input exp_t e);
        int   n = 0;
        logic acc = 1'b0;
        in_valid       = 1'b1;
        codeword_width = w;
        data_in        = cw;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                q.push_back(e);
                accepts++;
            end
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: counter model, stall stability and scoreboard pops.
    initial begin : monitor
        exp_t        e;
        logic        stall_prev = 1'b0;
        logic [31:0] prev_d = '0;
        logic        prev_c = 1'b0;
        logic        prev_f = 1'b0;
        logic        popped;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                model_corr  = 0;
                model_fatal = 0;
                stall_prev  = 1'b0;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                continue;
            end
            check("corr_cnt", 32'(corr_cnt), 32'(model_corr));
            check("fatal_cnt", 32'(fatal_cnt), 32'(model_fatal));
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", data_out, prev_d);
                check("stall_corr", 32'(err_corr), 32'(prev_c));
                check("stall_fatal", 32'(err_fatal), 32'(prev_f));
            end
            popped = 1'b0;
            e      = '0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", data_out);
                end else begin
                    e      = q.pop_front();
                    popped = 1'b1;
                    check("data_out", data_out, e.data);
                    check("err_corr", 32'(err_corr), 32'(e.corr));
                    check("err_fatal", 32'(err_fatal), 32'(e.fatal));
                end
            end
            if (cnt_clr) begin
                model_corr  = 0;
                model_fatal = 0;
            end else if (popped) begin
                if (e.corr && model_corr < CMAX) model_corr++;
                if (e.fatal && model_fatal < CMAX) model_fatal++;
            end
            stall_prev = out_valid && !out_ready;
            prev_d     = data_out;
            prev_c     = err_corr;
            prev_f     = err_fatal;
        end
    end

    initial begin : stim
        int a0;
        rst            = 1'b1;
        in_valid       = 1'b0;
        codeword_width = 2'b00;
        data_in        = '0;
        out_ready      = 1'b1;
        cnt_clr        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_flags", {30'd0, err_corr, err_fatal}, 32'd0);
        check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Clean loopback in all modes, then single/double/illegal cases.
        send(2'b00, 32'hA5, mk(32'hA, 1'b0, 1'b0));
        send(2'b01, enc(2'b01, 32'h5A5), mk(32'h5A5, 1'b0, 1'b0));
        send(2'b10, enc(2'b10, 32'h2ABCDEF), mk(32'h2ABCDEF, 1'b0, 1'b0));
        send(2'b10, enc(2'b10, 32'h2ABCDEF) ^ 32'h20, mk(32'h2ABCDEF, 1'b1, 1'b0));
        send(2'b01, enc(2'b01, 32'h5A5) ^ 32'h208, mk(32'h0, 1'b0, 1'b1));
        send(2'b01, enc(2'b01, 32'h5A5) ^ 32'h1, mk(32'h5A5, 1'b1, 1'b0));
        send(2'b10, enc(2'b10, 32'h2ABCDEF) ^ (32'd1 << 20), mk(32'h2ABCDEF, 1'b1, 1'b0));
        send(2'b00, enc(2'b00, 32'h3) ^ 32'h80, mk(32'h3, 1'b1, 1'b0));
        send(2'b11, 32'hDEADBEEF, mk(32'h0, 1'b0, 1'b1));
        send(2'b00, enc(2'b00, 32'h6), mk(32'h6, 1'b0, 1'b0));
        drain();

        // Back-pressure: sink stalls for 3 cycles under 4 back-to-back beats.
        out_ready = 1'b0;
        a0 = accepts;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(2'b00, enc(2'b00, 32'(i + 1)), mk(32'(i + 1), 1'b0, 1'b0));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_accepts", 32'(accepts - a0), 32'd2);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation and clear-vs-increment.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        check("clr_corr_cnt", 32'(corr_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(2'b00, enc(2'b00, 32'h5) ^ 32'h1, mk(32'h5, 1'b1, 1'b0));
        end
        drain();
        check("sat_corr_cnt", 32'(corr_cnt), 32'(CMAX));
        send(2'b00, enc(2'b00, 32'h9) ^ 32'h2, mk(32'h9, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        check("clr_beat_pending", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        check("clr_with_beat", 32'(corr_cnt), 32'd0);
        drain();

        // Reset mid-stream with a full, stalled pipe.
        out_ready = 1'b0;
        send(2'b01, enc(2'b01, 32'h123), mk(32'h123, 1'b0, 1'b0));
        send(2'b01, enc(2'b01, 32'h456), mk(32'h456, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_fatal_cnt", 32'(fatal_cnt), 32'd0);
        check("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send(2'b10, enc(2'b10, 32'h1234567), mk(32'h1234567, 1'b0, 1'b0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
